// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and serial line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a configurable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver_core.sv
// UART receive core: oversampled 8N1 recovery, LSB first, with one-cycle finish/frame_error strobes.
// Define UART_RX_PARITY_EN for 8E1 frames and a parity_error output.
module uart_receiver_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 bit_in,
  output logic [DATA_BITS-1:0] d,
  output logic                 finish,
  output logic                 frame_error
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_error
`endif
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rx;
  uart_state_t          state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 armed;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit;
`endif

  sync_2ff #(
    .RESET_VAL(LINE_IDLE)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (bit_in),
    .q    (rx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      armed       <= 1'b0;
      d           <= '0;
      finish      <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit   <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      finish      <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
      if (sample_tick) begin
        case (state)
          ST_IDLE: begin
            // Arming on a seen-high line keeps a held-low break from retriggering frames.
            if (rx == LINE_IDLE) begin
              armed <= 1'b1;
            end else if (armed) begin
              state    <= ST_START;
              tick_cnt <= '0;
            end
          end

          ST_START: begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              if (rx == START_BIT) begin
                state   <= ST_DATA;
                bit_cnt <= '0;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          ST_DATA: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt  <= '0;
              shift_reg <= {rx, shift_reg[DATA_BITS-1:1]};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt   <= '0;
              parity_bit <= rx;
              state      <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`endif

          ST_STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              state    <= ST_IDLE;
              if (rx == STOP_BIT) begin
                d <= shift_reg;
`ifdef UART_RX_PARITY_EN
                if ((^shift_reg) ^ parity_bit) begin
                  parity_error <= 1'b1;
                end else begin
                  finish <= 1'b1;
                end
`else
                finish <= 1'b1;
`endif
              end else begin
                frame_error <= 1'b1;
                armed       <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          default: begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver_core.sv
// Directed bench for uart_receiver_core: 16x oversampling, one sample_tick every 4th clk.
module tb_uart_receiver_core;
  import uart_pkg::*;

  localparam int BIT_CLKS = 64;  // 16 ticks * 4 clk

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_tick = 1'b0;
  logic       bit_in = 1'b1;
  logic [7:0] d;
  logic       finish;
  logic       frame_error;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
  int         npar = 0;
`endif

  int total = 0;
  int bad = 0;
  int nfin = 0;
  int nferr = 0;
  int noverlap = 0;
  logic [7:0] dq[$];

  uart_receiver_core #(
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sample_tick(sample_tick),
    .bit_in     (bit_in),
    .d          (d),
    .finish     (finish),
    .frame_error(frame_error)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_error(parity_error)
`endif
  );

  always #1 clk = ~clk;

  initial begin
    int ph = 0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      sample_tick = (ph == 0);
    end
  end

  always @(negedge clk) begin
    if (finish) begin
      nfin = nfin + 1;
      dq.push_back(d);
    end
    if (frame_error) nferr = nferr + 1;
    if (finish && frame_error) noverlap = noverlap + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_error) npar = npar + 1;
    if (parity_error && (finish || frame_error)) noverlap = noverlap + 1;
`endif
  end

  task automatic line_bit(input logic v);
    bit_in = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Reset lands right after a tick so no tick sees the synchronizer's reset-high value.
  task automatic reset_aligned();
    bit found = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      if (sample_tick) begin
        found = 1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL tick_align: no sample_tick seen within 8 clk");
    end
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    total++;
    if (d !== 8'h00 || finish !== 1'b0 || frame_error !== 1'b0) begin
      bad++;
      $display("FAIL midframe_reset_state: d=%h finish=%b ferr=%b required d=00 finish=0 ferr=0",
               d, finish, frame_error);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip,
                            input int rst_bit);
    line_bit(START_BIT);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) begin
        bit_in = b[i];
        repeat (BIT_CLKS / 2) @(negedge clk);
        reset_aligned();
        repeat (BIT_CLKS / 2) @(negedge clk);
      end else begin
        line_bit(b[i]);
      end
    end
`ifdef UART_RX_PARITY_EN
    line_bit((^b) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    line_bit(stop_v);
  endtask

  task automatic check_counts(input string name, input int fin_base, input int ferr_base,
                              input int exp_fin, input int exp_ferr);
    total++;
    if (nfin - fin_base !== exp_fin) begin
      bad++;
      $display("FAIL %s_finish_count: got %0d required %0d", name, nfin - fin_base, exp_fin);
    end
    total++;
    if (nferr - ferr_base !== exp_ferr) begin
      bad++;
      $display("FAIL %s_ferr_count: got %0d required %0d", name, nferr - ferr_base, exp_ferr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bit_in = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (d !== 8'h00 || finish !== 1'b0 || frame_error !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: d=%h finish=%b ferr=%b required d=00 finish=0 ferr=0",
               d, finish, frame_error);
    end
    total++;
    if (dut.state !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_state: got %0d required %0d", dut.state, ST_IDLE);
    end
    reset = 1'b0;
    line_bit(1'b1);
  endtask

  task automatic test_basic();
    int f0 = nfin, e0 = nferr;
    send_frame(8'hAB, 1'b1, 1'b0, -1);
    line_bit(1'b1);
    check_counts("basic", f0, e0, 1, 0);
    total++;
    if (dq.size() == 0 || dq[$] !== 8'hAB || d !== 8'hAB) begin
      bad++;
      $display("FAIL basic_data: d=%h required ab", d);
    end
  endtask

  task automatic test_framing();
    int f0 = nfin, e0 = nferr;
    send_frame(8'h5A, 1'b0, 1'b0, -1);
    check_counts("stop_low", f0, e0, 0, 1);
    total++;
    if (d !== 8'hAB) begin
      bad++;
      $display("FAIL stop_low_d_kept: d=%h required ab", d);
    end
    bit_in = 1'b0;
    repeat (30 * BIT_CLKS) @(negedge clk);
    check_counts("break", f0, e0, 0, 1);
    line_bit(1'b1);
    line_bit(1'b1);
    send_frame(8'h01, 1'b1, 1'b0, -1);
    line_bit(1'b1);
    check_counts("after_break", f0, e0, 1, 1);
    total++;
    if (d !== 8'h01) begin
      bad++;
      $display("FAIL after_break_data: d=%h required 01", d);
    end
  endtask

  task automatic test_glitch();
    int f0 = nfin, e0 = nferr;
    bit_in = 1'b0;
    repeat (20) @(negedge clk);
    bit_in = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check_counts("glitch", f0, e0, 0, 0);
    total++;
    if (dut.state !== ST_IDLE) begin
      bad++;
      $display("FAIL glitch_state: got %0d required %0d", dut.state, ST_IDLE);
    end
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    line_bit(1'b1);
    check_counts("post_glitch", f0, e0, 1, 0);
    total++;
    if (d !== 8'h3C) begin
      bad++;
      $display("FAIL post_glitch_data: d=%h required 3c", d);
    end
  endtask

  task automatic test_back_to_back();
    int f0 = nfin, e0 = nferr;
    int q0 = dq.size();
    logic [7:0] exp[3] = '{8'h55, 8'h00, 8'hFF};
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, 1'b0, -1);
    line_bit(1'b1);
    check_counts("b2b", f0, e0, 3, 0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (dq.size() < q0 + i + 1 || dq[q0+i] !== exp[i]) begin
        bad++;
        $display("FAIL b2b_data%0d: got %h required %h", i,
                 (dq.size() > q0 + i) ? dq[q0+i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_midframe_reset();
    int f0 = nfin, e0 = nferr;
    send_frame(8'hC3, 1'b1, 1'b0, 4);
    line_bit(1'b1);
    check_counts("mid_reset", f0, e0, 0, 0);
    total++;
    if (d !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset_d: d=%h required 00", d);
    end
    send_frame(8'h7E, 1'b1, 1'b0, -1);
    line_bit(1'b1);
    check_counts("post_reset", f0, e0, 1, 0);
    total++;
    if (d !== 8'h7E) begin
      bad++;
      $display("FAIL post_reset_data: d=%h required 7e", d);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int f0 = nfin, e0 = nferr, p0 = npar;
    send_frame(8'hAB, 1'b1, 1'b0, -1);
    line_bit(1'b1);
    check_counts("parity_ok", f0, e0, 1, 0);
    send_frame(8'hAB, 1'b1, 1'b1, -1);
    line_bit(1'b1);
    check_counts("parity_bad", f0, e0, 1, 0);
    total++;
    if (npar - p0 !== 1) begin
      bad++;
      $display("FAIL parity_error_count: got %0d required 1", npar - p0);
    end
    total++;
    if (d !== 8'hAB) begin
      bad++;
      $display("FAIL parity_data: d=%h required ab", d);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_midframe_reset();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    total++;
    if (noverlap !== 0) begin
      bad++;
      $display("FAIL pulse_overlap: got %0d cycles required 0", noverlap);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
